// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect/flush controls
// and the IF/ID register outputs seen by decode.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_ir;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_addr_err;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        input  flush,
        input  id_ready,
        output if_valid,
        output if_ir,
        output if_pc,
        output if_pc_plus4,
        output if_addr_err
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        output flush,
        output id_ready,
        input  if_valid,
        input  if_ir,
        input  if_pc,
        input  if_pc_plus4,
        input  if_addr_err
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register, redirect and flush handling.
// Define FETCH_HALFWORD_EN for a 16-bit memory port (two beats per instruction).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset_n,
    fetch_unit_if.master  bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic        free;
    logic        load;
    logic        misaligned;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_word;

    assign free       = !valid_q || bus.id_ready;
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign pc_plus4   = pc_q + 32'd4;

`ifdef FETCH_HALFWORD_EN
    typedef enum logic {S_FIRST = 1'b0, S_SECOND = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [15:0] upper_q, upper_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FIRST;
            upper_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            upper_q <= upper_d;
        end
    end

    // A redirect drops any half-captured instruction so halves never mix.
    always_comb begin
        state_d = state_q;
        upper_d = upper_q;
        if (bus.redirect_valid) begin
            state_d = S_FIRST;
            upper_d = 16'h0000;
        end else begin
            case (state_q)
                S_FIRST: begin
                    upper_d = bus.imem_rdata[15:0];
                    state_d = S_SECOND;
                end
                S_SECOND: begin
                    if (free && !bus.flush)
                        state_d = S_FIRST;
                end
                default: state_d = S_FIRST;
            endcase
        end
    end

    assign bus.imem_addr = (state_q == S_SECOND) ? (pc_q + 32'd2) : pc_q;
    assign load          = (state_q == S_SECOND) && free && !bus.redirect_valid && !bus.flush;
    assign fetch_word    = {upper_q, bus.imem_rdata[15:0]};
`else
    assign bus.imem_addr = pc_q;
    assign load          = free && !bus.redirect_valid && !bus.flush;
    assign fetch_word    = bus.imem_rdata;
`endif

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        ir_d    = ir_q;
        ipc_d   = ipc_q;
        pcp4_d  = pcp4_q;
        err_d   = err_q;

        if (bus.redirect_valid)
            pc_d = bus.redirect_pc;
        else if (load)
            pc_d = pc_plus4;

        // Without a load, an accepted (or empty) slot becomes empty; a
        // stalled slot keeps its instruction, including across a redirect.
        if (load) begin
            valid_d = 1'b1;
            ir_d    = misaligned ? 32'h0000_0000 : fetch_word;
            ipc_d   = pc_q;
            pcp4_d  = pc_plus4;
            err_d   = misaligned;
        end else if (free) begin
            valid_d = 1'b0;
        end

        if (bus.flush)
            valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            ir_q    <= 32'h0000_0000;
            ipc_q   <= 32'h0000_0000;
            pcp4_q  <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            ir_q    <= ir_d;
            ipc_q   <= ipc_d;
            pcp4_q  <= pcp4_d;
            err_q   <= err_d;
        end
    end

    assign bus.if_valid    = valid_q;
    assign bus.if_ir       = ir_q;
    assign bus.if_pc       = ipc_q;
    assign bus.if_pc_plus4 = pcp4_q;
    assign bus.if_addr_err = err_q;

endmodule
